// File: rtl/reg_intf_arb_pkg.sv
// Shared types and helpers for the register-interface arbiters.
// Default request/response structs can be overridden through the type parameters of the arbiter.
package reg_intf_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } arb_reg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } arb_reg_rsp_t;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_intf_rr_pick.sv
// Round-robin picker: first valid index at or after ptr_i, wrapping. Purely combinational, no backpressure.
module reg_intf_rr_pick
    import reg_intf_arb_pkg::*;
#(
    parameter  int NumReq = 2,
    localparam int IdxW   = idx_width(NumReq)
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic              any_valid_o,
    output logic [IdxW-1:0]   idx_o
);

    logic [IdxW:0]   sum;
    logic [IdxW-1:0] cand;

    // Walk from the farthest offset down so the closest valid to ptr_i is written last.
    always_comb begin
        any_valid_o = 1'b0;
        idx_o       = '0;
        sum         = '0;
        cand        = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            sum = {1'b0, ptr_i} + (IdxW+1)'(i);
            if (sum >= (IdxW+1)'(NumReq)) begin
                sum = sum - (IdxW+1)'(NumReq);
            end
            cand = sum[IdxW-1:0];
            if (valid_i[cand]) begin
                any_valid_o = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/reg_intf_arbiter.sv
// Round-robin share of one register-interface port: 1-cycle arbitration, grant held until ready/timeout/withdrawal.
// Non-granted requesters see ready=0 and must hold; hung downstream transfers end with a forced error.
module reg_intf_arbiter
    import reg_intf_arb_pkg::*;
#(
    parameter  int  NumReq        = 2,
    parameter  int  TimeoutCycles = 1024,
    parameter  type reg_req_t     = arb_reg_req_t,
    parameter  type reg_rsp_t     = arb_reg_rsp_t,
    localparam int  IdxW          = idx_width(NumReq)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  reg_req_t [NumReq-1:0] req_i,
    output reg_rsp_t [NumReq-1:0] rsp_o,
    output reg_req_t              req_o,
    input  reg_rsp_t              rsp_i,
    output logic                  busy_o,
    output logic [IdxW-1:0]       grant_idx_o,
    output logic                  timeout_o
);

    localparam int             CntW    = idx_width(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    arb_state_e        state_q;
    logic [IdxW-1:0]   grant_q;
    logic [IdxW-1:0]   rr_ptr_q;
    logic [IdxW-1:0]   rr_ptr_d;
    logic [CntW-1:0]   cnt_q;
    logic [CntW-1:0]   cnt_d;
    logic [NumReq-1:0] valid_vec;
    logic              pick_any;
    logic [IdxW-1:0]   pick_idx;
    reg_req_t          gnt_req;
    logic              busy, gnt_vld, done, tmo, withdraw;

    for (genvar k = 0; k < NumReq; k++) begin : g_valid
        assign valid_vec[k] = req_i[k].valid;
    end

    reg_intf_rr_pick #(
        .NumReq (NumReq)
    ) u_pick (
        .valid_i     (valid_vec),
        .ptr_i       (rr_ptr_q),
        .any_valid_o (pick_any),
        .idx_o       (pick_idx)
    );

    assign busy     = (state_q == ARB_BUSY);
    assign gnt_req  = req_i[grant_q];
    assign gnt_vld  = gnt_req.valid;
    assign done     = busy && gnt_vld && rsp_i.ready;
    // A withdrawn request never receives a response, not even a forced timeout.
    assign tmo      = busy && gnt_vld && (TimeoutCycles != 0) && (cnt_q == CntLast) && !rsp_i.ready;
    assign withdraw = busy && !gnt_vld;

    assign rr_ptr_d = (grant_q == IdxW'(NumReq - 1)) ? '0 : grant_q + 1'b1;
    assign cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        req_o = '0;
        rsp_o = '0;
        if (busy) begin
            req_o = gnt_req;
            if (tmo) begin
                req_o.valid          = 1'b0;
                rsp_o[grant_q].ready = 1'b1;
                rsp_o[grant_q].error = 1'b1;
            end else if (gnt_vld) begin
                rsp_o[grant_q] = rsp_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        cnt_q   <= '0;
                        state_q <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (done || tmo || withdraw) begin
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ARB_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign busy_o      = busy;
    assign grant_idx_o = grant_q;
    assign timeout_o   = tmo;

endmodule

// File: tb/tb_reg_intf_arbiter.sv
// Self-checking bench for reg_intf_arbiter with four requesters and an 8-cycle timeout.
module tb_reg_intf_arbiter;
    import reg_intf_arb_pkg::*;

    localparam int N  = 4;
    localparam int TO = 8;

    logic                   clk = 1'b0;
    logic                   rst_i;
    arb_reg_req_t [N-1:0]   req_i;
    arb_reg_rsp_t [N-1:0]   rsp_o;
    arb_reg_req_t           req_o;
    arb_reg_rsp_t           rsp_i;
    logic                   busy_o;
    logic [1:0]             grant_idx_o;
    logic                   timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        int          idx;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          delay;   // ready asserted in BUSY cycle delay+1; negative = never
        logic        err;
        logic [31:0] rdata;
        int          exp_g;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[5];
    int   rr_exp[5];

    always #5 clk = ~clk;

    reg_intf_arbiter #(
        .NumReq        (N),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .rsp_o       (rsp_o),
        .req_o       (req_o),
        .rsp_i       (rsp_i),
        .busy_o      (busy_o),
        .grant_idx_o (grant_idx_o),
        .timeout_o   (timeout_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: every upstream ready must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (!rst_i) begin
            for (int k = 0; k < N; k++) begin
                if (rsp_o[k].ready) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: requester %0d got ready, none expected", k);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("rsp_idx", k, mon_e.idx);
                        check("rsp_rdata", rsp_o[k].rdata, mon_e.rdata);
                        check("rsp_error", rsp_o[k].error, mon_e.err);
                    end
                end else if (!busy_o || k != int'(grant_idx_o)) begin
                    check("rsp_quiet", rsp_o[k], '0);
                end
            end
        end
    end

    // Single-requester transaction; called at posedge+1 while the arbiter is idle.
    task automatic serve(input vec_t v);
        int cyc;
        int to_cnt;
        int to_cyc;
        req_i[v.idx].valid = 1'b1;
        req_i[v.idx].addr  = v.addr;
        req_i[v.idx].write = v.wr;
        req_i[v.idx].wdata = v.wdata;
        req_i[v.idx].wstrb = v.strb;
        @(posedge clk); #1;
        check("busy_after_arb", busy_o, 1'b1);
        check("grant_idx", grant_idx_o, v.exp_g);
        check("req_o_valid", req_o.valid, 1'b1);
        check("req_o_addr", req_o.addr, v.addr);
        check("req_o_write", req_o.write, v.wr);
        check("req_o_wdata", req_o.wdata, v.wdata);
        check("req_o_wstrb", req_o.wstrb, v.strb);
        cyc    = 1;
        to_cnt = 0;
        to_cyc = 0;
        while (busy_o && cyc <= 20) begin
            if (v.delay >= 0 && cyc == v.delay + 1) begin
                rsp_i.ready = 1'b1;
                rsp_i.rdata = v.rdata;
                rsp_i.error = v.err;
                sb_q.push_back('{v.idx, v.rdata, v.err});
            end else begin
                rsp_i = '0;
            end
            if (v.delay < 0 && cyc == TO) begin
                sb_q.push_back('{v.idx, 32'h0, 1'b1});
            end
            #1;
            if (timeout_o) begin
                to_cnt++;
                to_cyc = cyc;
                check("req_o_valid_on_timeout", req_o.valid, 1'b0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        rsp_i              = '0;
        req_i[v.idx].valid = 1'b0;
        check("busy_cycles", cyc - 1, (v.delay >= 0) ? v.delay + 1 : TO);
        check("timeout_pulses", to_cnt, (v.delay >= 0) ? 0 : 1);
        if (v.delay < 0) begin
            check("timeout_cycle", to_cyc, TO);
        end
    endtask

    initial begin
        vecs[0] = '{3, 1'b0, 32'h20, 32'h0,         4'h0, 1,  1'b0, 32'hCAFE_F00D, 3};
        vecs[1] = '{0, 1'b0, 32'h24, 32'h0,         4'h0, 0,  1'b1, 32'h0,         0};
        vecs[2] = '{1, 1'b1, 32'h28, 32'h0000_55AA, 4'h3, 7,  1'b0, 32'h0,         1};
        vecs[3] = '{0, 1'b1, 32'h2C, 32'h1234_5678, 4'hF, -1, 1'b0, 32'h0,         0};
        vecs[4] = '{2, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 2,  1'b0, 32'h0,         2};
        rr_exp  = '{0, 1, 2, 3, 0};

        rst_i = 1'b1;
        req_i = '0;
        rsp_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy_o, 1'b0);
        check("reset_grant", grant_idx_o, 2'd0);
        check("reset_req_o", req_o.valid, 1'b0);
        check("reset_timeout", timeout_o, 1'b0);
        check("reset_rsp_o", rsp_o, '0);
        rst_i = 1'b0;
        @(posedge clk); #1;

        // All four held valid with downstream always ready: strict rotation from pointer 0.
        for (int k = 0; k < N; k++) begin
            req_i[k].valid = 1'b1;
            req_i[k].addr  = 32'h100 + 32'(k * 4);
        end
        rsp_i.ready = 1'b1;
        rsp_i.rdata = 32'h0000_5A5A;
        for (int i = 0; i < 5; i++) sb_q.push_back('{rr_exp[i], 32'h0000_5A5A, 1'b0});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("rr_busy", busy_o, 1'b1);
            check("rr_grant", grant_idx_o, rr_exp[i]);
            check("rr_addr", req_o.addr, 32'h100 + 32'(rr_exp[i] * 4));
            @(posedge clk); #1;
            check("rr_idle_gap", busy_o, 1'b0);
        end
        req_i = '0;
        rsp_i = '0;

        for (int i = 0; i < 5; i++) begin
            serve(vecs[i]);
            if (vecs[i].delay < 0) begin
                // Late downstream ready after the timeout must not reach anyone.
                rsp_i.ready = 1'b1;
                rsp_i.rdata = 32'hBAD0_BAD0;
                #1;
                check("late_ready_req_o", req_o.valid, 1'b0);
                check("late_ready_busy", busy_o, 1'b0);
                @(posedge clk); #1;
                rsp_i = '0;
            end
        end

        // Pointer sits at 3 after granting 2: requester 3 beats requester 0.
        req_i[0].valid = 1'b1;
        req_i[0].addr  = 32'h40;
        req_i[3].valid = 1'b1;
        req_i[3].addr  = 32'h4C;
        @(posedge clk); #1;
        check("sim_first_grant", grant_idx_o, 2'd3);
        check("sim_first_busy", busy_o, 1'b1);
        rsp_i.ready = 1'b1;
        rsp_i.rdata = 32'h0000_0033;
        sb_q.push_back('{3, 32'h0000_0033, 1'b0});
        sb_q.push_back('{0, 32'h0000_0033, 1'b0});
        @(posedge clk); #1;
        check("sim_gap", busy_o, 1'b0);
        req_i[3].valid = 1'b0;
        @(posedge clk); #1;
        check("sim_second_grant", grant_idx_o, 2'd0);
        @(posedge clk); #1;
        req_i[0].valid = 1'b0;
        rsp_i = '0;

        // Reset while requester 1 is granted.
        req_i[1].valid = 1'b1;
        @(posedge clk); #1;
        check("pre_reset_grant", grant_idx_o, 2'd1);
        rst_i = 1'b1;
        #1;
        check("async_reset_valid", req_o.valid, 1'b0);
        check("async_reset_busy", busy_o, 1'b0);
        check("async_reset_grant", grant_idx_o, 2'd0);
        req_i[0].valid = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;
        check("post_reset_grant", grant_idx_o, 2'd0);
        check("post_reset_busy", busy_o, 1'b1);

        // Withdrawal with a coincident downstream ready: no response, back to idle.
        req_i[0].valid = 1'b0;
        req_i[1].valid = 1'b0;
        rsp_i.ready    = 1'b1;
        #1;
        check("withdraw_req_o", req_o.valid, 1'b0);
        @(posedge clk); #1;
        check("withdraw_idle", busy_o, 1'b0);
        rsp_i = '0;

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
